// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Summary  : 1W/2R register file. Entry 0 always reads as zero. A sequential
//            bulk clear zeroes one entry per cycle.
//            Define REGFILE_BYPASS_EN to forward same-edge writes and clears
//            to the read ports.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [DEPTH-1:0] WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE_A,
    input  logic [DEPTH-1:0] RADDR_A,
    output logic [WIDTH-1:0] RDATA_A,
    input  logic             RE_B,
    input  logic [DEPTH-1:0] RADDR_B,
    output logic [WIDTH-1:0] RDATA_B,
    input  logic             CLR,
    output logic             BUSY
);

    localparam int               C_ENTRIES  = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] C_LAST_IDX = {DEPTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_index;
    logic [DEPTH-1:0] w_index_nxt;
    logic             w_clr_en;
    logic             w_wr_en;
    logic [WIDTH-1:0] r_mem [C_ENTRIES];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_clr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (CLR) begin
                    w_state_nxt = ST_CLEAR;
                    w_index_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_clr_en    = 1'b1;
                w_index_nxt = r_index + DEPTH'(1);
                if (r_index == C_LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_index_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    // A clear request takes priority over a write issued in the same cycle.
    assign w_wr_en = WE && (r_state == ST_IDLE) && !CLR && (WADDR != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < C_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_clr_en) begin
                r_mem[r_index] <= '0;
            end
            if (w_wr_en) begin
                r_mem[WADDR] <= WDATA;
            end
        end
    end

    always_comb begin
        w_rd_a = r_mem[RADDR_A];
        w_rd_b = r_mem[RADDR_B];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (RADDR_A == WADDR)) begin
            w_rd_a = WDATA;
        end
        if (w_wr_en && (RADDR_B == WADDR)) begin
            w_rd_b = WDATA;
        end
        if (w_clr_en && (RADDR_A == r_index)) begin
            w_rd_a = '0;
        end
        if (w_clr_en && (RADDR_B == r_index)) begin
            w_rd_b = '0;
        end
`endif
        if (RADDR_A == '0) begin
            w_rd_a = '0;
        end
        if (RADDR_B == '0) begin
            w_rd_b = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (RE_A) begin
                r_rdata_a <= w_rd_a;
            end
            if (RE_B) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    assign RDATA_A = r_rdata_a;
    assign RDATA_B = r_rdata_b;
    assign BUSY    = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// Testbench for regfile_mp: directed stimulus, cycle-level reference model,
// plus literal expectations for reset, write/read, collision and clear.
module tb_regfile_mp;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int NUM   = 2 ** DEPTH;

    logic             CLK     = 1'b0;
    logic             RST_N   = 1'b1;
    logic             WE      = 1'b0;
    logic [DEPTH-1:0] WADDR   = '0;
    logic [WIDTH-1:0] WDATA   = '0;
    logic             RE_A    = 1'b0;
    logic [DEPTH-1:0] RADDR_A = '0;
    logic [WIDTH-1:0] RDATA_A;
    logic             RE_B    = 1'b0;
    logic [DEPTH-1:0] RADDR_B = '0;
    logic [WIDTH-1:0] RDATA_B;
    logic             CLR     = 1'b0;
    logic             BUSY;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE_A(RE_A), .RADDR_A(RADDR_A), .RDATA_A(RDATA_A),
        .RE_B(RE_B), .RADDR_B(RADDR_B), .RDATA_B(RDATA_B),
        .CLR(CLR), .BUSY(BUSY)
    );

    logic clk_run = 1'b0;
    always #5 if (clk_run) CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain array plus a countdown of remaining clear steps.
    int           m_mem [NUM];
    int           m_rd_a, m_rd_b;
    int           m_clr_left;

    function automatic int model_read(input int addr, input bit wr_ok, input int zi);
        int v;
        v = m_mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && addr == int'(WADDR)) v = int'(WDATA);
        if (addr == zi) v = 0;
`endif
        if (addr == 0) v = 0;
        return v;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM; i++) m_mem[i] = 0;
            m_rd_a     = 0;
            m_rd_b     = 0;
            m_clr_left = 0;
        end else begin
            bit wr_ok;
            int zi;
            wr_ok = WE && (m_clr_left == 0) && !CLR && (WADDR != 0);
            zi    = (m_clr_left > 0) ? (NUM - m_clr_left) : -1;
            if (RE_A) m_rd_a = model_read(int'(RADDR_A), wr_ok, zi);
            if (RE_B) m_rd_b = model_read(int'(RADDR_B), wr_ok, zi);
            if (zi >= 0) m_mem[zi] = 0;
            if (wr_ok) m_mem[WADDR] = int'(WDATA);
            if (m_clr_left > 0) m_clr_left--;
            else if (CLR) m_clr_left = NUM;
        end
    end

    always @(negedge CLK) begin
        if (chk_en && RST_N) begin
            check("model_rdata_a", 32'(RDATA_A), 32'(m_rd_a));
            check("model_rdata_b", 32'(RDATA_B), 32'(m_rd_b));
            check("model_busy", 32'(BUSY), 32'(m_clr_left > 0));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_in();
        WE = 1'b0; CLR = 1'b0; RE_A = 1'b0; RE_B = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        idle_in();
        for (int i = 0; i < NUM; i++) begin
            RE_A = 1'b1; RADDR_A = DEPTH'(i);
            RE_B = 1'b1; RADDR_B = DEPTH'(NUM - 1 - i);
            cyc();
            check(tag, 32'(RDATA_A), 32'h0);
            check(tag, 32'(RDATA_B), 32'h0);
        end
        idle_in();
    endtask

    task automatic write(input int addr, input int data);
        idle_in();
        WE = 1'b1; WADDR = DEPTH'(addr); WDATA = WIDTH'(data);
        cyc();
        WE = 1'b0;
    endtask

    initial begin
        int n;
        // Reset with the clock stopped: outputs must clear without any edge.
        #3 RST_N = 1'b0;
        #1;
        check("reset_rdata_a", 32'(RDATA_A), 32'h0);
        check("reset_rdata_b", 32'(RDATA_B), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);
        clk_run = 1'b1;
        @(negedge CLK);
        RST_N  = 1'b1;
        chk_en = 1'b1;
        read_all_zero("reset_read");

        // Write then read on both ports.
        write(5, 8'hA5);
        RE_A = 1'b1; RADDR_A = 5'd5; RE_B = 1'b1; RADDR_B = 5'd0;
        cyc();
        check("wr_rd_a", 32'(RDATA_A), 32'hA5);
        check("wr_rd_b", 32'(RDATA_B), 32'h00);

        // RE low holds the last value.
        idle_in(); RADDR_A = 5'd3; RADDR_B = 5'd3;
        cyc();
        check("hold_a", 32'(RDATA_A), 32'hA5);

        // Same-address read on both ports.
        RE_A = 1'b1; RE_B = 1'b1; RADDR_A = 5'd5; RADDR_B = 5'd5;
        cyc();
        check("same_addr_b", 32'(RDATA_B), 32'hA5);

        // Read-during-write collision.
        write(7, 8'h11);
        WE = 1'b1; WADDR = 5'd7; WDATA = 8'h3C; RE_A = 1'b1; RADDR_A = 5'd7; RE_B = 1'b0;
        cyc();
`ifdef REGFILE_BYPASS_EN
        check("collision_a", 32'(RDATA_A), 32'h3C);
`else
        check("collision_a", 32'(RDATA_A), 32'h11);
`endif
        idle_in(); RE_A = 1'b1;
        cyc();
        check("after_collision_a", 32'(RDATA_A), 32'h3C);

        // Writes to address 0 are discarded.
        write(0, 8'h77);
        RE_A = 1'b1; RADDR_A = 5'd0;
        cyc();
        check("addr0_read", 32'(RDATA_A), 32'h0);

        // Fill, then clear with a simultaneous (dropped) write.
        for (int i = 0; i < NUM; i++) write(i, 8'hFF);
        idle_in();
        CLR = 1'b1; WE = 1'b1; WADDR = 5'd3; WDATA = 8'h55;
        cyc();
        idle_in();
        n = 0;
        while (BUSY === 1'b1 && n < NUM + 8) begin
            WE    = (n == 5);
            WADDR = 5'd31; WDATA = 8'h55;
            CLR   = (n == 10);
            RE_A  = 1'b1; RADDR_A = DEPTH'(n);
            RE_B  = 1'b1; RADDR_B = DEPTH'(n + 3);
            cyc();
            n++;
        end
        check("clear_busy_cycles", 32'(n), 32'd32);
        check("clear_done_busy", 32'(BUSY), 32'h0);
        read_all_zero("clear_read");

        // Reset in the middle of a clear.
        write(9, 8'h9A);
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        repeat (9) cyc();
        check("midclr_busy_before", 32'(BUSY), 32'h1);
        #2 RST_N = 1'b0;
        #1;
        check("midclr_busy_reset", 32'(BUSY), 32'h0);
        check("midclr_rdata_a", 32'(RDATA_A), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        RE_A = 1'b1; RADDR_A = 5'd9;
        cyc();
        check("midclr_entry9", 32'(RDATA_A), 32'h0);
        write(12, 8'h5A);
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && n < NUM + 8) begin
            RE_A = 1'b1; RADDR_A = 5'd12;
            cyc();
            n++;
        end
        check("restart_busy_cycles", 32'(n), 32'd32);
        idle_in();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 5: address width; 2**DEPTH entries.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on posedge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port WE, input, 1: write enable.
REQ-006 SHALL have port WADDR, input, DEPTH: write address.
REQ-007 SHALL have port WDATA, input, WIDTH: write data.
REQ-008 SHALL have port RE_A, input, 1: read enable, port A.
REQ-009 SHALL have port RADDR_A, input, DEPTH: read address, port A.
REQ-010 SHALL have port RDATA_A, output, WIDTH: registered read data, port A.
REQ-011 SHALL have ports RE_B, RADDR_B and RDATA_B, identical to port A.
REQ-012 SHALL have port CLR, input, 1: bulk-clear request.
REQ-013 SHALL have port BUSY, output, 1: clear sequence in progress.

Function
REQ-014 Entry 0 SHALL always read as 0; writes to address 0 SHALL be discarded.
REQ-015 With WE=1, BUSY=0 and WADDR!=0, the entry SHALL take WDATA at the posedge.
REQ-016 With RE_x=1, RDATA_x SHALL load the addressed entry at the posedge (1-cycle latency).
REQ-017 With RE_x=0, RDATA_x SHALL hold its value.
REQ-018 Ports A and B SHALL be independent and may read the same address in one cycle.
REQ-019 The clear FSM SHALL have states IDLE and CLEAR.
REQ-020 From IDLE, CLR=1 at a posedge SHALL enter CLEAR with the index counter at 0; BUSY=1 from that edge.
REQ-021 In CLEAR, each posedge SHALL zero entry[index] and increment the index.
REQ-022 After zeroing index 2**DEPTH-1, the FSM SHALL return to IDLE, and BUSY SHALL be 0 after that edge.
REQ-023 A full clear SHALL take exactly 2**DEPTH cycles.
REQ-024 CLR SHALL be ignored while BUSY=1.
REQ-025 WE SHALL be ignored while BUSY=1, including the edge at which CLR is accepted; such writes are dropped, not queued.
REQ-026 Reads SHALL be serviced during CLEAR and return current contents: entries at or below the last cleared index read 0.
REQ-027 If CLR and WE are both asserted in IDLE, CLR SHALL win and the write SHALL be dropped.

Reset
REQ-028 RST_N=0 SHALL immediately, independent of CLK, set every entry, RDATA_A and RDATA_B to 0, BUSY to 0, the FSM to IDLE and the index to 0.
REQ-029 Reset asserted mid-clear SHALL abort the sequence; operation SHALL resume in IDLE on the first posedge after RST_N rises.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select read-during-write behaviour.
REQ-031 With REGFILE_BYPASS_EN defined:
- a read at the same edge as an accepted write to the same address returns WDATA;
- a read of the index being zeroed in CLEAR returns 0.
REQ-032 Without REGFILE_BYPASS_EN, those reads SHALL return the pre-edge contents (read-before-write).
REQ-033 Address 0 SHALL read 0 in both configurations.

Verification
REQ-034 Reset then read: RST_N low with CLK stopped -> RDATA_A=RDATA_B=0 and BUSY=0 immediately; reads of all 32 addresses return 0.
REQ-035 Write/read: WE=1, WADDR=5, WDATA=8'hA5, then RE_A=RE_B=1 at addresses 5 and 0 the next cycle -> RDATA_A=8'hA5 and RDATA_B=0 one cycle later.
REQ-036 Collision: WE=1 at address 7, WDATA=8'h3C, with RE_A=1 at address 7 in the same cycle (old value 8'h11):
- -> RDATA_A=8'h3C with REGFILE_BYPASS_EN;
- -> RDATA_A=8'h11 without it.
REQ-037 Clear: fill all entries with 8'hFF, pulse CLR:
- -> BUSY high for exactly 32 cycles;
- -> WE with WDATA=8'h55 issued mid-clear is dropped;
- -> all entries read 0 afterwards.
REQ-038 Reset mid-clear: CLR accepted, RST_N pulsed low at cycle 10 -> BUSY=0 at once; after RST_N rises, CLR restarts the sequence at index 0 and lasts 32 cycles.
